// File: rtl/uart_line_packer.sv
// Packs a UART byte stream into 512-bit lines (first byte in the MSBs) and hands
// each line to a memory controller. Optional idle timeout: UART_LINE_PACKER_TIMEOUT_EN.
module uart_line_packer #(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              write_o,
  output logic [511:0]      write_data_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {COLLECT, ISSUE, WAIT} state_t;

  state_t     state, state_nx;
  logic [5:0] byte_cnt;
  logic [5:0] slot;
  logic       timeout_hit;
  logic       write_nx, busy_nx;

`ifdef UART_LINE_PACKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = (state == COLLECT) && (byte_cnt != 6'd0) &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (state != COLLECT || byte_cnt == 6'd0 || rx_valid_i || timeout_hit)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
      if (timeout_hit) timeout_o <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  // A strobe coinciding with a timeout restarts the line at slot 0.
  assign slot = timeout_hit ? 6'd0 : byte_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: if (rx_valid_i && slot == 6'd63) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (ready_i) state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
  end

  always_comb begin
    write_nx = (state_nx == ISSUE);
    busy_nx  = (state_nx != COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      write_o <= write_nx;
      busy_o  <= busy_nx;
    end
  end

  // Line buffer doubles as write_data_o; it is only written in COLLECT, so it
  // stays stable while the controller owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt     <= 6'd0;
      write_data_o <= '0;
      addr_o       <= '0;
      overrun_o    <= 1'b0;
    end else begin
      if (state == COLLECT) begin
        if (rx_valid_i) begin
          write_data_o[{~slot, 3'b000} +: 8] <= rx_data_i;
          byte_cnt <= slot + 6'd1;
        end else if (timeout_hit) begin
          byte_cnt <= 6'd0;
        end
      end else if (rx_valid_i) begin
        overrun_o <= 1'b1;
      end
      if (state == WAIT && ready_i) addr_o <= addr_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_line_packer.sv
// Bench for uart_line_packer: queue-based line model checked every cycle, plus
// directed literal checks on write latency, slot placement, address wrap and reset.
`timescale 1ns/1ps
module tb_uart_line_packer;
  localparam int ADDR_W = 2;
  localparam int TCYC   = 50;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              ready = 1'b0;
  logic              write, busy, ovr, to;
  logic [511:0]      wdata;
  logic [ADDR_W-1:0] addr;

  int n_cmp = 0;
  int n_bad = 0;
  int n_writes = 0;
  int w0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_line_packer #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .write_o(write), .write_data_o(wdata), .addr_o(addr), .ready_i(ready),
    .busy_o(busy), .overrun_o(ovr), .timeout_o(to)
  );

  task automatic cmp(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: bytes queue up until 64 are held; then the line is outstanding until
  // a ready arrives after the write cycle. Anything received meanwhile is lost.
  logic [7:0]   q[$];
  bit           m_pend, m_write, m_ovr, m_to;
  logic [511:0] m_line;
  int           m_addr;
`ifdef UART_LINE_PACKER_TIMEOUT_EN
  int           m_idle;
`endif

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_pend = 0; m_write = 0; m_ovr = 0; m_to = 0; m_line = '0; m_addr = 0;
`ifdef UART_LINE_PACKER_TIMEOUT_EN
      m_idle = 0;
`endif
    end else if (m_pend) begin
      if (rx_valid) m_ovr = 1;
      if (ready && !m_write) begin
        m_pend = 0;
        m_addr = (m_addr + 1) % (1 << ADDR_W);
      end
      m_write = 0;
    end else begin
`ifdef UART_LINE_PACKER_TIMEOUT_EN
      if (q.size() == 0) m_idle = 0;
      else if (m_idle == TCYC) begin q.delete(); m_to = 1; m_idle = 0; end
      else if (!rx_valid) m_idle++;
`endif
      if (rx_valid) begin
        q.push_back(rx_data);
`ifdef UART_LINE_PACKER_TIMEOUT_EN
        m_idle = 0;
`endif
        if (q.size() == 64) begin
          for (int i = 0; i < 64; i++) m_line[511-8*i -: 8] = q[i];
          q.delete();
          m_pend = 1; m_write = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("write_o", write, m_write);
      cmp("busy_o", busy, m_pend);
      cmp("overrun_o", ovr, m_ovr);
      cmp("timeout_o", to, m_to);
      cmp("addr_o", addr, m_addr);
      if (m_pend) cmp("write_data_o", wdata, m_line);
    end
    if (write === 1'b1) n_writes++;
  end

  task automatic strobe(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    cmp("rst_write", write, 0);
    cmp("rst_data", wdata, 0);
    cmp("rst_addr", addr, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_ovr", ovr, 0);
    cmp("rst_to", to, 0);
    rst = 1'b0;

    // line 1: bytes 0x00..0x3F
    for (int i = 0; i < 64; i++) strobe(8'(i));
    cmp("l1_write_lat", write, 1);
    cmp("l1_slot0", wdata[511:504], 8'h00);
    cmp("l1_slot63", wdata[7:0], 8'h3F);
    cmp("l1_addr", addr, 0);
    @(negedge clk);
    cmp("l1_single_pulse", write, 0);
    repeat (3) @(negedge clk);
    cmp("l1_busy_wait", busy, 1);
    pulse_ready();
    cmp("l1_ack_busy", busy, 0);
    cmp("l1_ack_addr", addr, 1);

    // line 2, then drops in WAIT and coincident with ready
    for (int i = 0; i < 64; i++) strobe(8'(i) ^ 8'h5A);
    cmp("l2_write", write, 1);
    cmp("l2_addr", addr, 1);
    cmp("l2_slot0", wdata[511:504], 8'h5A);
    cmp("l2_slot63", wdata[7:0], 8'h65);
    @(negedge clk);
    strobe(8'hEE);
    cmp("wait_drop_ovr", ovr, 1);
    cmp("wait_hold", wdata[7:0], 8'h65);
    ready = 1'b1;
    strobe(8'hDD);
    ready = 1'b0;
    cmp("coinc_busy", busy, 0);
    cmp("coinc_addr", addr, 2);
    pulse_ready();
    cmp("ready_in_collect", addr, 2);

    // line 3 must start at slot 0 despite the dropped bytes
    for (int i = 0; i < 64; i++) strobe(8'h80 + 8'(i));
    cmp("l3_slot0", wdata[511:504], 8'h80);
    cmp("l3_slot63", wdata[7:0], 8'hBF);
    cmp("l3_addr", addr, 2);
    @(negedge clk); pulse_ready();
    cmp("l3_ack_addr", addr, 3);

    for (int i = 0; i < 64; i++) strobe(~8'(i));
    cmp("l4_addr", addr, 3);
    @(negedge clk); pulse_ready();
    cmp("l4_wrap", addr, 0);

    for (int i = 0; i < 64; i++) strobe(8'(i) + 8'h1);
    cmp("l5_write", write, 1);
    cmp("l5_addr", addr, 0);

    // reset during WAIT abandons the line
    @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    w0 = n_writes;
    cmp("rstw_busy", busy, 0);
    cmp("rstw_data", wdata, 0);
    repeat (4) @(negedge clk);
    pulse_ready();
    cmp("rstw_ready_ignored", addr, 0);
    @(negedge clk);
    cmp("rstw_no_write", n_writes, w0);

    // reset mid-line, then a fresh line
    for (int i = 0; i < 30; i++) strobe(8'hFF);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    w0 = n_writes;
    for (int i = 0; i < 64; i++) strobe(8'hC0 ^ 8'(i));
    cmp("fresh_write", write, 1);
    cmp("fresh_slot0", wdata[511:504], 8'hC0);
    cmp("fresh_slot29", wdata[511-8*29 -: 8], 8'hDD);
    cmp("fresh_slot63", wdata[7:0], 8'hFF);
    cmp("fresh_addr", addr, 0);
    @(negedge clk);
    cmp("fresh_one_write", n_writes, w0 + 1);
    pulse_ready();

    // 10 bytes, 50 idle cycles, then a 64-byte burst
    for (int i = 0; i < 10; i++) strobe(8'h10 + 8'(i));
    repeat (TCYC) @(negedge clk);
    cmp("idle_no_to_yet", to, 0);
`ifdef UART_LINE_PACKER_TIMEOUT_EN
    for (int i = 0; i < 64; i++) strobe(8'h40 + 8'(i));
    cmp("to_write", write, 1);
    cmp("to_flag", to, 1);
    cmp("to_slot0", wdata[511:504], 8'h40);
    cmp("to_slot63", wdata[7:0], 8'h7F);
    cmp("to_addr", addr, 1);
`else
    for (int i = 0; i < 54; i++) strobe(8'h40 + 8'(i));
    cmp("noto_write", write, 1);
    cmp("noto_flag", to, 0);
    cmp("noto_slot0", wdata[511:504], 8'h10);
    cmp("noto_slot10", wdata[431:424], 8'h40);
    cmp("noto_slot63", wdata[7:0], 8'h75);
    cmp("noto_addr", addr, 1);
    for (int i = 54; i < 64; i++) strobe(8'h40 + 8'(i));
`endif
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_line_packer.md
UART_LINE_PACKER -- requirements
Module: uart_line_packer

Interface
REQ-001 Parameter: ADDR_W, default 10, width of the line address counter.
REQ-002 Parameter: TIMEOUT_CYC, default 100000, number of idle clk cycles before a partial line is discarded (used only with TIMEOUT_EN).
REQ-003 The block SHALL have one clock, clk; reset SHALL be rst, synchronous and active-high.
REQ-004 clk  input  1  system clock, the memory controller's CPU-side clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rx_data_i  input  8  received UART byte.
REQ-007 rx_valid_i  input  1  single-cycle strobe; rx_data_i is valid in this cycle.
REQ-008 write_o  output  1  single-cycle write request to the memory controller.
REQ-009 write_data_o  output  512  assembled line.
REQ-010 addr_o  output  ADDR_W  line address of the current write.
REQ-011 ready_i  input  1  single-cycle pulse from the memory controller; the write has completed.
REQ-012 busy_o  output  1  high while in ISSUE or WAIT.
REQ-013 overrun_o  output  1  sticky flag; a byte was dropped.
REQ-014 timeout_o  output  1  sticky flag; a partial line was discarded.

Function
REQ-015 FSM states SHALL be COLLECT, ISSUE and WAIT; reset state is COLLECT.
REQ-016 COLLECT: each rx_valid_i SHALL store rx_data_i at byte slot byte_cnt (0..63) and increment byte_cnt.
- Slot k maps to write_data_o[511-8k -: 8], so the first byte lands in [511:504].
REQ-017 COLLECT with rx_valid_i and byte_cnt==63: store the byte, clear byte_cnt to 0, go to ISSUE on the next cycle.
REQ-018 ISSUE SHALL last exactly one cycle.
- write_o=1 in that cycle only.
- Go to WAIT.
- Latency: write_o rises 1 cycle after the 64th strobe.
REQ-019 WAIT: on ready_i, addr_o SHALL increment by 1, wrapping from 2^ADDR_W-1 to 0, and the FSM SHALL return to COLLECT.
REQ-020 write_data_o and addr_o SHALL be held stable from ISSUE until ready_i is accepted.
REQ-021 rx_valid_i in ISSUE or WAIT SHALL drop the byte and set overrun_o.
- This includes the cycle in which ready_i is accepted.
REQ-022 ready_i in COLLECT or ISSUE SHALL be ignored, with no state change.
REQ-023 overrun_o and timeout_o SHALL clear only on rst.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 On rst, every output and register SHALL take its reset value in the following cycle:
- write_o=0, write_data_o=0, addr_o=0, busy_o=0, overrun_o=0, timeout_o=0, byte_cnt=0, state=COLLECT.
REQ-026 rst asserted mid-line or during WAIT SHALL abandon the line.
- No write_o pulse is generated afterwards.
- A later ready_i in COLLECT is ignored.

Configuration
REQ-027 Macro UART_LINE_PACKER_TIMEOUT_EN, when defined, SHALL add an idle counter that runs only in COLLECT with byte_cnt!=0 and clears on every rx_valid_i.
REQ-028 With the macro defined, when the counter reaches TIMEOUT_CYC the block SHALL:
- set byte_cnt to 0;
- set timeout_o;
- leave addr_o unchanged;
- issue no write.
- A strobe arriving in that same cycle SHALL be stored as slot 0.
REQ-029 Without the macro there SHALL be no idle counter, timeout_o SHALL be constant 0, and partial lines SHALL be held indefinitely.

Verification
REQ-030 64 strobes carrying bytes 0x00..0x3F -> one write_o pulse 1 cycle after the last strobe, with write_data_o[511:504]=0x00 and [7:0]=0x3F, and addr_o=0.
REQ-031 ready_i 5 cycles after write_o, then a second 64-byte line -> second write_o with addr_o=1; busy_o high from ISSUE through the ready_i cycle.
REQ-032 Strobe during WAIT, and a strobe coincident with ready_i -> both bytes dropped, overrun_o=1, next line still aligned to slot 0.
REQ-033 ADDR_W=2, five completed lines -> addr_o sequence 0,1,2,3,0.
REQ-034 rst after 30 bytes, then 64 fresh bytes -> exactly one write_o carrying only the fresh bytes, addr_o=0.
REQ-035 With TIMEOUT_EN and TIMEOUT_CYC=50: 10 bytes, idle 50 cycles, then 64 bytes -> timeout_o=1, one write_o with the new bytes; without the macro the same stimulus -> write_o after the 54th byte of the second burst, timeout_o=0.
